// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt request controller: source count default,
// configuration register map, FSM state encoding and the fixed-priority helper.
package irq_pkg;

  localparam int NUM_SRC_DEF = 8;

  localparam logic [1:0] ADDR_ENABLE    = 2'd0;
  localparam logic [1:0] ADDR_PENDING   = 2'd1;
  localparam logic [1:0] ADDR_ACTIVE_ID = 2'd2;
  localparam logic [1:0] ADDR_RESERVED  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  // Lowest set index wins; an all-zero vector yields 0.
  function automatic logic [3:0] lowest_idx(input logic [15:0] vec);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Per-source level sampler and rising-edge detector. Macro IRQ_SYNC_EN inserts a
// 2-flop synchronizer ahead of edge detection.
module irq_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic src,
  output logic rise
);

  logic level_s;
  logic valid_s;
  logic level_d_r;
  logic armed_r;

`ifdef IRQ_SYNC_EN
  logic       sync1_r;
  logic       sync2_r;
  logic [1:0] fill_r;

  // Synchronizer chain; fill_r marks when sync2_r reflects a post-reset sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      fill_r  <= 2'b00;
    end else begin
      sync1_r <= src;
      sync2_r <= sync1_r;
      fill_r  <= {fill_r[0], 1'b1};
    end
  end

  assign level_s = sync2_r;
  assign valid_s = fill_r[1];
`else
  assign level_s = src;
  assign valid_s = 1'b1;
`endif

  // A source held high across reset must be seen low once before it may fire.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_d_r <= 1'b0;
      armed_r   <= 1'b0;
    end else begin
      level_d_r <= level_s;
      armed_r   <= armed_r | (~level_s & valid_s);
    end
  end

  assign rise = level_s & ~level_d_r & armed_r;

endmodule

// File: rtl/interrupt_request_ctrl.sv
// Fixed-priority, non-nesting interrupt request controller with ENABLE/PENDING/
// ACTIVE_ID registers. Optional IRQ_SYNC_EN adds input synchronizers.
module interrupt_request_ctrl
  import irq_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  input  logic               isr_return,
  output logic               interupt_signanl,
  output logic [3:0]         irq_id,
  output logic               irq_active
);

  logic [NUM_SRC-1:0] rise_s;
  logic [NUM_SRC-1:0] clr_s;
  logic [NUM_SRC-1:0] enable_r;
  logic [NUM_SRC-1:0] pending_r;
  logic [15:0]        req_wide_s;
  irq_state_e         state_r;
  logic [3:0]         irq_id_r;
  logic               pulse_r;
  logic               active_r;
  logic               unused_wdata_s;

  assign unused_wdata_s = ^cfg_wdata[31:NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_edge_sync u_edge (
      .clk   (clk),
      .reset (reset),
      .src   (irq_src[g]),
      .rise  (rise_s[g])
    );
  end

  // Enable mask register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable_r <= {NUM_SRC{1'b0}};
    end else if (cfg_we && (cfg_addr == ADDR_ENABLE)) begin
      enable_r <= cfg_wdata[NUM_SRC-1:0];
    end else begin
      enable_r <= enable_r;
    end
  end

  // Clear sources: W1C writes and the ISR return of the serviced id.
  always_comb begin
    clr_s = {NUM_SRC{1'b0}};
    if (cfg_we && (cfg_addr == ADDR_PENDING)) begin
      clr_s = cfg_wdata[NUM_SRC-1:0];
    end else begin
      clr_s = {NUM_SRC{1'b0}};
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if ((state_r == ST_SERVICE) && isr_return && (irq_id_r == 4'(i))) begin
        clr_s[i] = 1'b1;
      end else begin
        clr_s[i] = clr_s[i];
      end
    end
  end

  // Pending latch; a fresh edge beats a clear of the same bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_r <= {NUM_SRC{1'b0}};
    end else begin
      pending_r <= (pending_r & ~clr_s) | rise_s;
    end
  end

  // Widen the masked request vector for the priority helper.
  always_comb begin
    req_wide_s = 16'd0;
    req_wide_s[NUM_SRC-1:0] = pending_r & enable_r;
  end

  // Request FSM with registered pulse, id and active flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      irq_id_r <= 4'd0;
      pulse_r  <= 1'b0;
      active_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_wide_s != 16'd0) begin
            state_r  <= ST_REQ;
            irq_id_r <= lowest_idx(req_wide_s);
            pulse_r  <= 1'b1;
            active_r <= 1'b1;
          end else begin
            state_r  <= ST_IDLE;
            pulse_r  <= 1'b0;
            active_r <= 1'b0;
          end
        end
        ST_REQ: begin
          state_r  <= ST_SERVICE;
          pulse_r  <= 1'b0;
          active_r <= 1'b1;
        end
        ST_SERVICE: begin
          if (isr_return) begin
            state_r  <= ST_IDLE;
            active_r <= 1'b0;
          end else begin
            state_r  <= ST_SERVICE;
            active_r <= 1'b1;
          end
          pulse_r <= 1'b0;
        end
        default: begin
          state_r  <= ST_IDLE;
          pulse_r  <= 1'b0;
          active_r <= 1'b0;
        end
      endcase
    end
  end

  // Register read mux; unused bits read as zero.
  always_comb begin
    cfg_rdata = 32'd0;
    case (cfg_addr)
      ADDR_ENABLE:    cfg_rdata[NUM_SRC-1:0] = enable_r;
      ADDR_PENDING:   cfg_rdata[NUM_SRC-1:0] = pending_r;
      ADDR_ACTIVE_ID: begin
        cfg_rdata[3:0] = irq_id_r;
        cfg_rdata[31]  = active_r;
      end
      ADDR_RESERVED:  cfg_rdata = 32'd0;
      default:        cfg_rdata = 32'd0;
    endcase
  end

  assign interupt_signanl = pulse_r;
  assign irq_id           = irq_id_r;
  assign irq_active       = active_r;

endmodule

// File: tb/tb_interrupt_request_ctrl.sv
// Directed plus randomized bench for interrupt_request_ctrl against a
// behavioural model of pending/enable/service rules.
module tb_interrupt_request_ctrl;

  localparam int N = 8;
`ifdef IRQ_SYNC_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] irq_src;
  logic         cfg_we;
  logic [1:0]   cfg_addr;
  logic [31:0]  cfg_wdata;
  logic [31:0]  cfg_rdata;
  logic         isr_return;
  logic         interupt_signanl;
  logic [3:0]   irq_id;
  logic         irq_active;

  int checks = 0;
  int errors = 0;

  // model state: mode 0=idle, 1=requesting, 2=in service
  logic [N-1:0] m_pend, m_en, m_prev, m_seen;
  int           m_mode;
  logic [3:0]   m_id;
  logic [N-1:0] m_hist[$];

  interrupt_request_ctrl #(.NUM_SRC(N)) dut (
    .clk              (clk),
    .reset            (reset),
    .irq_src          (irq_src),
    .cfg_we           (cfg_we),
    .cfg_addr         (cfg_addr),
    .cfg_wdata        (cfg_wdata),
    .cfg_rdata        (cfg_rdata),
    .isr_return       (isr_return),
    .interupt_signanl (interupt_signanl),
    .irq_id           (irq_id),
    .irq_active       (irq_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_prev = '0; m_seen = '0;
    m_mode = 0; m_id = 4'd0;
    m_hist.delete();
  endtask

  task automatic model_edge();
    logic [N-1:0] s, rise, clr, old_pend, old_en;
    bit valid;
    m_hist.push_back(irq_src);
    if (m_hist.size() > DLY) begin
      valid = 1'b1;
      s = m_hist[m_hist.size() - 1 - DLY];
    end else begin
      valid = 1'b0;
      s = '0;
    end
    while (m_hist.size() > DLY + 1) void'(m_hist.pop_front());
    rise = s & ~m_prev & m_seen;
    if (valid) m_seen = m_seen | ~s;
    m_prev = s;
    old_pend = m_pend;
    old_en = m_en;
    clr = '0;
    if (cfg_we && cfg_addr == 2'd1) clr = cfg_wdata[N-1:0];
    if (cfg_we && cfg_addr == 2'd0) m_en = cfg_wdata[N-1:0];
    case (m_mode)
      0: if ((old_pend & old_en) != '0) begin
           m_mode = 1;
           for (int i = N - 1; i >= 0; i--) if (old_pend[i] && old_en[i]) m_id = 4'(i);
         end
      1: m_mode = 2;
      2: if (isr_return) begin
           clr[m_id] = 1'b1;
           m_mode = 0;
         end
      default: m_mode = 0;
    endcase
    m_pend = (old_pend & ~clr) | rise;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_pulse"},  {31'd0, interupt_signanl}, {31'd0, m_mode == 1});
    check({tag, "_active"}, {31'd0, irq_active},       {31'd0, m_mode != 0});
    check({tag, "_id"},     {28'd0, irq_id},           {28'd0, m_id});
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] exp;
    for (int a = 0; a < 4; a++) begin
      cfg_we = 1'b0;
      cfg_addr = 2'(a);
      #1;
      case (a)
        0: exp = {24'd0, m_en};
        1: exp = {24'd0, m_pend};
        2: exp = {(m_mode != 0), 27'd0, m_id};
        default: exp = 32'd0;
      endcase
      check($sformatf("%s_reg%0d", tag, a), cfg_rdata, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cfg_we = 1'b0;
    isr_return = 1'b0;
    check_outputs("cyc");
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
  endtask

  task automatic isr();
    isr_return = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b0; irq_src = '0; cfg_we = 1'b0; cfg_addr = 2'd0;
    cfg_wdata = 32'd0; isr_return = 1'b0;
    model_reset();
    #1;
    check_outputs("reset");
    check_regs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    ticks(3);

    // basic single source
    wr(2'd0, 32'h08);
    irq_src[3] = 1'b1;
    ticks(DLY + 3);
    check("basic_id", {28'd0, irq_id}, 32'd3);
    check_regs("basic");
    ticks(2);
    isr();
    check_regs("basic_done");
    irq_src = '0;
    ticks(DLY + 2);

    // simultaneous sources: lower index first
    wr(2'd0, 32'hFF);
    irq_src = 8'h24;
    ticks(DLY + 3);
    check("prio_first", {28'd0, irq_id}, 32'd2);
    isr();
    tick();
    check("prio_second_pulse", {31'd0, interupt_signanl}, 32'd1);
    check("prio_second_id", {28'd0, irq_id}, 32'd5);
    tick();
    isr();
    irq_src = '0;
    ticks(DLY + 2);

    // masked source latches pending, W1C clears it
    wr(2'd0, 32'h00);
    irq_src[1] = 1'b1;
    ticks(DLY + 2);
    check_regs("mask");
    wr(2'd1, 32'h02);
    check_regs("w1c");
    wr(2'd0, 32'h02);
    ticks(3);
    irq_src = '0;
    ticks(DLY + 2);

    // new edge on the same cycle as ISR return keeps pending
    wr(2'd0, 32'hFF);
    irq_src[4] = 1'b1;
    ticks(DLY + 3);
    check("race_id", {28'd0, irq_id}, 32'd4);
    irq_src[4] = 1'b0;
    ticks(DLY + 1);
    irq_src[4] = 1'b1;
    ticks(DLY);
    isr();
    check_regs("race");
    tick();
    check("race_again_pulse", {31'd0, interupt_signanl}, 32'd1);
    check("race_again_id", {28'd0, irq_id}, 32'd4);
    tick();
    isr();
    irq_src = '0;
    ticks(DLY + 2);

    // reset during service, source held high
    wr(2'd0, 32'h01);
    irq_src[0] = 1'b1;
    ticks(DLY + 3);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_pulse", {31'd0, interupt_signanl}, 32'd0);
    check("rst_active", {31'd0, irq_active}, 32'd0);
    check("rst_id", {28'd0, irq_id}, 32'd0);
    check_regs("rst_mid");
    @(negedge clk) reset = 1'b1;
    ticks(4);
    wr(2'd0, 32'h01);
    ticks(DLY + 4);
    check_regs("held_high");
    irq_src[0] = 1'b0;
    ticks(DLY + 2);
    irq_src[0] = 1'b1;
    ticks(DLY + 3);
    check("rearm_active", {31'd0, irq_active}, 32'd1);
    isr();
    irq_src = '0;
    ticks(DLY + 2);

    // stray return in idle
    wr(2'd0, 32'h00);
    irq_src[6] = 1'b1;
    ticks(DLY + 2);
    check_regs("stray_pre");
    isr();
    check_regs("stray_post");
    wr(2'd1, 32'hFF);
    irq_src = '0;
    ticks(DLY + 2);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      int r;
      irq_src = irq_src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      r = $urandom_range(0, 15);
      if (r == 0) begin
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = $urandom;
      end else if (r == 1) begin
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = $urandom;
      end else if (r == 2) begin
        cfg_we = 1'b1; cfg_addr = 2'($urandom_range(2, 3)); cfg_wdata = $urandom;
      end
      isr_return = ((m_mode == 2) && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 15) == 0);
      tick();
      if (c % 16 == 0) check_regs("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
